// File: rtl/scoring_pkg.sv
// Shared types and constants for the round sequencer of the scoring datapath.
package scoring_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CLEAR     = 3'd1,
        S_COUNTDOWN = 3'd2,
        S_DANCE     = 3'd3,
        S_TALLY     = 3'd4,
        S_DONE      = 3'd5
    } ctrl_state_t;

    localparam int DEFAULT_TALLY_CYCLES = 4;

endpackage

// File: rtl/scoring_ctrl_event_counter.sv
// Terminal-count event counter: counts tick while en is high and pulses tc
// (combinationally) on the tick that reaches TERMINAL, restarting from zero.
module event_counter #(
    parameter int TERMINAL = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    input  logic tick,
    output logic tc
);

    // Count only reaches TERMINAL-1 before restarting, so this width never wraps.
    localparam int CNT_W = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;

    logic [CNT_W-1:0] cnt;
    logic             at_last;

    assign at_last = (cnt == CNT_W'(TERMINAL - 1));
    assign tc      = ~clr & en & tick & at_last;

    // Event count: clear wins, terminal tick restarts, qualified tick advances.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr || tc) begin
            cnt <= '0;
        end else if (en && tick) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/scoring_ctrl.sv
// Round sequencer: clear, countdown, then NUM_MOVES move windows. Gates the
// per-pixel counting enable during each window and issues one update per window.
module scoring_ctrl
    import scoring_pkg::*;
#(
    parameter int  COUNTDOWN_FRAMES = 180,
    parameter int  FRAMES_PER_MOVE  = 30,
    parameter int  NUM_MOVES        = 16,
    parameter int  TALLY_CYCLES     = DEFAULT_TALLY_CYCLES,
    localparam int MOVE_W           = (NUM_MOVES > 1) ? $clog2(NUM_MOVES) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              pause,
    input  logic              frame_start,
    input  logic              in_window,
    output logic              counting,
    output logic              update,
    output logic              score_clear,
    output logic [MOVE_W-1:0] move_idx,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state_out
);

    localparam int TALLY_W = (TALLY_CYCLES > 1) ? $clog2(TALLY_CYCLES) : 1;

    ctrl_state_t        state;
    logic [TALLY_W-1:0] tally_cnt;
    logic               cd_tc;
    logic               mv_tc;

    // Each frame counter is held at zero outside the state it times, so every
    // entry to COUNTDOWN or DANCE starts a fresh count without extra control.
    event_counter #(.TERMINAL(COUNTDOWN_FRAMES)) u_countdown_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (~pause),
        .clr   (state != S_COUNTDOWN),
        .tick  (frame_start),
        .tc    (cd_tc)
    );

    event_counter #(.TERMINAL(FRAMES_PER_MOVE)) u_move_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (~pause),
        .clr   (state != S_DANCE),
        .tick  (frame_start),
        .tc    (mv_tc)
    );

    // Pixel enable must stay aligned with in_window, so it is not registered.
    assign counting  = (state == S_DANCE) & in_window & ~pause;
    assign busy      = (state != S_IDLE) & (state != S_DONE);
    assign done      = (state == S_DONE);
    assign state_out = state;

    // Round FSM with registered update/score_clear pulses; abort overrides everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            move_idx    <= '0;
            tally_cnt   <= '0;
            update      <= 1'b0;
            score_clear <= 1'b0;
        end else begin
            update      <= 1'b0;
            score_clear <= 1'b0;
            if (abort) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            state       <= S_CLEAR;
                            score_clear <= 1'b1;
                        end
                    end
                    S_CLEAR: begin
                        move_idx <= '0;
                        state    <= S_COUNTDOWN;
                    end
                    S_COUNTDOWN: begin
                        if (cd_tc) begin
                            state <= S_DANCE;
                        end
                    end
                    S_DANCE: begin
                        if (mv_tc) begin
                            state     <= S_TALLY;
                            update    <= 1'b1;
                            tally_cnt <= '0;
                        end
                    end
                    S_TALLY: begin
                        if (tally_cnt == TALLY_W'(TALLY_CYCLES - 1)) begin
                            if (move_idx == MOVE_W'(NUM_MOVES - 1)) begin
                                state <= S_DONE;
                            end else begin
                                move_idx <= move_idx + MOVE_W'(1);
                                state    <= S_DANCE;
                            end
                        end else begin
                            tally_cnt <= tally_cnt + TALLY_W'(1);
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scoring_ctrl.sv
// Testbench for scoring_ctrl: directed round scenarios plus random stimulus,
// every cycle checked against a phase/frames-remaining reference model.
module tb_scoring_ctrl;

    localparam int CD  = 2;
    localparam int FPM = 3;
    localparam int NM  = 2;
    localparam int TC  = 4;

    localparam int P_IDLE = 0, P_CLEAR = 1, P_COUNTDOWN = 2, P_DANCE = 3, P_TALLY = 4, P_DONE = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, abort, pause, frame_start, in_window;
    logic       counting, update, score_clear, busy, done;
    logic [0:0] move_idx;
    logic [2:0] state_out;

    int errors = 0;
    int checks = 0;
    int upd_seen = 0;

    // reference model
    int m_phase, m_frames_left, m_tally_left, m_move;
    bit m_upd, m_clr;
    bit frame_toggle = 1'b0;

    scoring_ctrl #(
        .COUNTDOWN_FRAMES (CD),
        .FRAMES_PER_MOVE  (FPM),
        .NUM_MOVES        (NM),
        .TALLY_CYCLES     (TC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .pause       (pause),
        .frame_start (frame_start),
        .in_window   (in_window),
        .counting    (counting),
        .update      (update),
        .score_clear (score_clear),
        .move_idx    (move_idx),
        .busy        (busy),
        .done        (done),
        .state_out   (state_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_frames_left = 0;
        m_tally_left = 0;
        m_move = 0;
        m_upd = 1'b0;
        m_clr = 1'b0;
    endtask

    // Advance the model by one clock edge given the inputs present at that edge.
    task automatic model_update(input bit s, input bit a, input bit p, input bit f);
        m_upd = 1'b0;
        m_clr = 1'b0;
        if (a) begin
            m_phase = P_IDLE;
        end else if (m_phase == P_IDLE || m_phase == P_DONE) begin
            if (s) begin
                m_phase = P_CLEAR;
                m_clr = 1'b1;
            end
        end else if (m_phase == P_CLEAR) begin
            m_move = 0;
            m_frames_left = CD;
            m_phase = P_COUNTDOWN;
        end else if (m_phase == P_COUNTDOWN || m_phase == P_DANCE) begin
            if (f && !p) begin
                m_frames_left--;
                if (m_frames_left == 0) begin
                    if (m_phase == P_COUNTDOWN) begin
                        m_phase = P_DANCE;
                        m_frames_left = FPM;
                    end else begin
                        m_phase = P_TALLY;
                        m_tally_left = TC;
                        m_upd = 1'b1;
                    end
                end
            end
        end else if (m_phase == P_TALLY) begin
            m_tally_left--;
            if (m_tally_left == 0) begin
                if (m_move == NM - 1) begin
                    m_phase = P_DONE;
                end else begin
                    m_move++;
                    m_frames_left = FPM;
                    m_phase = P_DANCE;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("state_out", 8'(state_out), 8'(m_phase));
        chk("update", 8'(update), 8'(m_upd));
        chk("score_clear", 8'(score_clear), 8'(m_clr));
        chk("move_idx", 8'(move_idx), 8'(m_move));
        chk("busy", 8'(busy), 8'(m_phase != P_IDLE && m_phase != P_DONE));
        chk("done", 8'(done), 8'(m_phase == P_DONE));
        chk("counting", 8'(counting), 8'(m_phase == P_DANCE && in_window && !pause));
        if (update === 1'b1) upd_seen++;
    endtask

    // One clock cycle: drive inputs, check outputs, take the edge, advance the model.
    task automatic step(input bit s, input bit a, input bit p, input bit f, input bit w);
        start = s; abort = a; pause = p; frame_start = f; in_window = w;
        #1;
        check_all();
        @(posedge clk);
        model_update(s, a, p, f);
        @(negedge clk);
    endtask

    task automatic run_to(input string tag, input int target, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (m_phase == target) break;
            step(1'b0, 1'b0, 1'b0, frame_toggle, 1'b1);
            frame_toggle = ~frame_toggle;
        end
        chk(tag, 8'(state_out), 8'(target));
    endtask

    initial begin
        reset = 1'b0;
        start = 0; abort = 0; pause = 0; frame_start = 0; in_window = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state", 8'(state_out), 8'd0);
        chk("rst_update", 8'(update), 8'd0);
        chk("rst_clear", 8'(score_clear), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        chk("rst_move", 8'(move_idx), 8'd0);
        reset = 1'b1;
        @(negedge clk);

        // start, clear pulse, countdown into DANCE
        step(1, 0, 0, 0, 0);
        chk("clear_state", 8'(state_out), 8'd1);
        chk("clear_pulse", 8'(score_clear), 8'd1);
        step(0, 0, 0, 0, 0);
        chk("countdown_state", 8'(state_out), 8'd2);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1);
        chk("dance_state", 8'(state_out), 8'd3);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // full round with in_window high
        upd_seen = 0;
        run_to("round1_done", P_DONE, 200);
        chk("round1_updates", 8'(upd_seen), 8'd2);
        chk("round1_done", 8'(done), 8'd1);
        chk("round1_busy", 8'(busy), 8'd0);

        // pause mid-DANCE
        step(1, 0, 0, 0, 0);
        run_to("pause_dance", P_DANCE, 20);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 1, 1);
            step(0, 0, 1, 0, 1);
        end
        chk("pause_hold", 8'(state_out), 8'd3);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1);
        chk("pause_still_dance", 8'(state_out), 8'd3);
        step(0, 0, 0, 1, 1);
        chk("pause_tally", 8'(state_out), 8'd4);
        chk("pause_update", 8'(update), 8'd1);
        run_to("round2_done", P_DONE, 200);

        // start and abort together from DONE: abort wins
        step(1, 1, 0, 0, 0);
        chk("sa_state", 8'(state_out), 8'd0);
        chk("sa_clear", 8'(score_clear), 8'd0);

        // new round, start while busy, abort on second DANCE frame
        step(1, 0, 0, 0, 0);
        chk("restart_clear", 8'(score_clear), 8'd1);
        run_to("abort_dance", P_DANCE, 20);
        chk("restart_move", 8'(move_idx), 8'd0);
        step(1, 0, 0, 0, 1);
        chk("busy_start", 8'(state_out), 8'd3);
        chk("busy_start_clear", 8'(score_clear), 8'd0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1);
        upd_seen = 0;
        step(0, 1, 0, 1, 1);
        chk("abort_state", 8'(state_out), 8'd0);
        chk("abort_update", 8'(update), 8'd0);
        chk("abort_clear", 8'(score_clear), 8'd0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, i % 2, 1);
        chk("abort_no_update", 8'(upd_seen), 8'd0);

        // asynchronous reset in the middle of TALLY
        step(1, 0, 0, 0, 0);
        run_to("pre_reset_tally", P_TALLY, 100);
        step(0, 0, 0, 0, 1);
        start = 0; abort = 0; pause = 0; frame_start = 0; in_window = 1;
        #2 reset = 1'b0;
        #1;
        chk("arst_state", 8'(state_out), 8'd0);
        chk("arst_update", 8'(update), 8'd0);
        chk("arst_clear", 8'(score_clear), 8'd0);
        chk("arst_busy", 8'(busy), 8'd0);
        chk("arst_counting", 8'(counting), 8'd0);
        chk("arst_move", 8'(move_idx), 8'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        upd_seen = 0;
        for (int i = 0; i < 20; i++) step(0, 0, 0, i % 2, 1);
        chk("arst_no_update", 8'(upd_seen), 8'd0);

        // random stimulus against the model
        for (int i = 0; i < 600; i++) begin
            bit s, a, p, f, w;
            s = ($urandom_range(0, 19) == 0);
            a = ($urandom_range(0, 79) == 0);
            p = ($urandom_range(0, 7) == 0);
            f = ($urandom_range(0, 2) == 0);
            w = 1'($urandom_range(0, 1));
            step(s, a, p, f, w);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
